// File: rtl/imm_ext_pkg.sv
// Shared mode encoding for the immediate-extension pipeline.
package imm_ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZEXT     = 2'd0;
  localparam ext_mode_t EXT_SEXT     = 2'd1;
  localparam ext_mode_t EXT_SEXT_SHL = 2'd2;
  localparam ext_mode_t EXT_UPPER    = 2'd3;

endpackage

// File: rtl/ext_pipe_stage.sv
// One valid/ready register slice: a valid bit plus a W-bit payload.
// Loads when empty or when its contents leave downstream in the same cycle.
module ext_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         load;

  assign in_ready  = !flush && (!valid_reg || out_ready);
  assign load      = in_valid && in_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // Payload is cleared too so the result bus reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (flush)
        valid_reg <= 1'b0;
      else if (load)
        valid_reg <= 1'b1;
      else if (out_ready)
        valid_reg <= 1'b0;
      if (load)
        data_reg <= in_data;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate extender: S1 holds the raw immediate and mode, the
// extension is computed combinationally from S1 and captured by S2.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int WIDE_W = OUT_W + SHIFT;

  generate
    if (IN_W < 1 || IN_W > OUT_W || SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_params
      $error("imm_ext_pipe: need 1 <= IN_W <= OUT_W and 0 <= SHIFT < OUT_W");
    end
  endgenerate

  logic              s1_valid;
  logic              s2_can_load;
  logic [IN_W+1:0]   s1_q;
  logic [OUT_W:0]    s2_in;
  logic [OUT_W:0]    s2_q;
  ext_mode_t         s1_mode;
  logic [IN_W-1:0]   s1_imm;
  logic [OUT_W-1:0]  zext;
  logic [OUT_W-1:0]  sext;
  logic [WIDE_W-1:0] wide;
  logic [SHIFT:0]    lost;
  logic [OUT_W-1:0]  res;
  logic              ovf;

  ext_pipe_stage #(.W(IN_W + 2)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_mode, in_data}),
    .out_valid (s1_valid),
    .out_ready (s2_can_load),
    .out_data  (s1_q)
  );

  assign {s1_mode, s1_imm} = s1_q;

  assign zext = OUT_W'(s1_imm);
  assign sext = OUT_W'($signed(s1_imm));
  assign wide = WIDE_W'($signed(s1_imm)) << SHIFT;
  // Discarded bits plus the kept sign bit: any disagreement means overflow.
  assign lost = wide[WIDE_W-1:OUT_W-1];

  always_comb begin
    res = zext;
    ovf = 1'b0;
    case (s1_mode)
      EXT_ZEXT:     res = zext;
      EXT_SEXT:     res = sext;
      EXT_SEXT_SHL: begin
        res = wide[OUT_W-1:0];
        ovf = (|lost) && !(&lost);
      end
      EXT_UPPER:    res = zext << (OUT_W - IN_W);
    endcase
  end

  assign s2_in = {ovf, res};

  ext_pipe_stage #(.W(OUT_W + 1)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_can_load),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {out_ovf, out_data} = s2_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: vector table, back-pressure/flush/reset sequences and
// a randomized stream checked against an arithmetic reference model.
module tb_imm_ext_pipe;

  localparam int SHIFT_TB = 2;

  logic        clk;
  logic        rst_n;

  logic        flush, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [31:0] out_data;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [31:0] b_in_data;
  logic [1:0]  b_in_mode;
  logic [31:0] b_out_data;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  imm_ext_pipe #(.IN_W(32), .OUT_W(32), .SHIFT(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_recv  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: treat the immediate as an integer and apply the mode's arithmetic.
  function automatic void ref_ext(input int in_w, input logic [31:0] d, input logic [1:0] m,
                                  output logic [31:0] r, output logic o);
    longint u, s, v;
    u = longint'(d) & ((longint'(1) << in_w) - 1);
    s = u[in_w-1] ? u - (longint'(1) << in_w) : u;
    o = 1'b0;
    v = u;
    case (m)
      2'd0: v = u;
      2'd1: v = s;
      2'd2: begin
        v = s * (longint'(1) << SHIFT_TB);
        o = (v < -(longint'(1) << 31)) || (v >= (longint'(1) << 31));
      end
      default: v = u << (32 - in_w);
    endcase
    r = v[31:0];
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  exp_t q[$];

  // Scoreboard for the 16-bit instance: handshakes are sampled mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    exp_t x;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          x = q.pop_front();
          check("stream_data", 64'(out_data), 64'(x.d));
          check("stream_ovf", 64'(out_ovf), 64'(x.o));
          n_recv++;
          $display("out  data=%h ovf=%b exp=%h/%b", out_data, out_ovf, x.d, x.o);
        end
      end
      if (in_valid && in_ready) begin
        ref_ext(16, 32'(in_data), in_mode, e.d, e.o);
        q.push_back(e);
      end
      if (flush) q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wide;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [31:0] dout;
    logic        ovf;
  } vec_t;

  // Single isolated transaction; caller guarantees empty pipe and out_ready=1.
  task automatic run_vec(input vec_t v);
    logic ov;
    if (v.wide) begin
      b_in_valid = 1'b1; b_in_data = v.din; b_in_mode = v.mode;
    end else begin
      in_valid = 1'b1; in_data = v.din[15:0]; in_mode = v.mode;
    end
    @(negedge clk);
    check("vec_in_ready", 64'(v.wide ? b_in_ready : in_ready), 64'd1);
    tick();
    in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    check("vec_gap", 64'(v.wide ? b_out_valid : out_valid), 64'd0);
    tick();
    @(negedge clk);
    ov = v.wide ? b_out_valid : out_valid;
    check("vec_out_valid", 64'(ov), 64'd1);
    check("vec_data", 64'(v.wide ? b_out_data : out_data), 64'(v.dout));
    check("vec_ovf", 64'(v.wide ? b_out_ovf : out_ovf), 64'(v.ovf));
    $display("vec  w=%0d mode=%0d in=%h out=%h ovf=%b", v.wide ? 32 : 16, v.mode, v.din,
             v.wide ? b_out_data : out_data, v.wide ? b_out_ovf : out_ovf);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[14];
    vec_t        rv;
    logic [15:0] items[3];
    logic [31:0] ex0;
    logic        exo;
    int          acc, idx, r0, sent;

    vt[0]  = '{1'b0, 2'd1, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    vt[1]  = '{1'b0, 2'd0, 32'h0000_8001, 32'h0000_8001, 1'b0};
    vt[2]  = '{1'b0, 2'd3, 32'h0000_1234, 32'h1234_0000, 1'b0};
    vt[3]  = '{1'b0, 2'd2, 32'h0000_FFFF, 32'hFFFF_FFFC, 1'b0};
    vt[4]  = '{1'b0, 2'd2, 32'h0000_8000, 32'hFFFE_0000, 1'b0};
    vt[5]  = '{1'b0, 2'd2, 32'h0000_7FFF, 32'h0001_FFFC, 1'b0};
    vt[6]  = '{1'b0, 2'd1, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0};
    vt[7]  = '{1'b0, 2'd3, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0};
    vt[8]  = '{1'b1, 2'd2, 32'h4000_0000, 32'h0000_0000, 1'b1};
    vt[9]  = '{1'b1, 2'd2, 32'hE000_0000, 32'h8000_0000, 1'b0};
    vt[10] = '{1'b1, 2'd2, 32'h2000_0000, 32'h8000_0000, 1'b1};
    vt[11] = '{1'b1, 2'd2, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b1};
    vt[12] = '{1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vt[13] = '{1'b1, 2'd3, 32'h1234_5678, 32'h1234_5678, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;

    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_w_out_valid", 64'(b_out_valid), 64'd0);
    #9 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_w_in_ready", 64'(b_in_ready), 64'd1);
    tick();

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Back-pressure: three offers with downstream stalled.
    for (int i = 0; i < 3; i++) items[i] = 16'($urandom) | 16'h0001;
    ref_ext(16, 32'(items[0]), 2'd1, ex0, exo);
    r0 = n_recv;
    out_ready = 1'b0; acc = 0; idx = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1; in_data = items[idx]; in_mode = 2'd1;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        if (idx < 2) idx++;
      end
      tick();
    end
    check("bp_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check("bp_hold_data", 64'(out_data), 64'(ex0));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    check("bp_delivered", 64'(n_recv - r0), 64'd3);

    // Randomized stream with random back-pressure.
    r0 = n_recv; sent = 0;
    for (int c = 0; c < 2000 && sent < 100; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("stream_sent", 64'(sent), 64'd100);
    check("stream_recv", 64'(n_recv - r0), 64'd100);

    // Full throughput with out_ready held high.
    r0 = n_recv; acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_mode = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("tput_accepted", 64'(acc), 64'd20);
    check("tput_recv", 64'(n_recv - r0), 64'd20);

    // Flush with both stages full.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_mode = 2'd0;
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    out_ready = 1'b1;
    rv.wide = 1'b0; rv.mode = 2'($urandom_range(0, 3)); rv.din = 32'(16'($urandom));
    ref_ext(16, rv.din, rv.mode, rv.dout, rv.ovf);
    run_vec(rv);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom) | 16'h0100; in_mode = 2'd0;
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst_no_pulse", 64'(out_valid), 64'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
